// File: rtl/timer_ctrl.sv
// timer_ctrl: APB register front-end and sequencer for the 8-bit timer counter.
//   Registers: TDR (start value), TCR (UD/EN/CKS + LOAD strobe), TSR (flags, W1C),
//   TIE (interrupt enables). Generates the load pulse, the flag-clear pulses,
//   the prescaled count enable clk_ena and a registered level interrupt.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   APB slave: psel, penable, pwrite, paddr, pwdata -> prdata, pready, pslverr
//   To counter: start_counter, up_down, enable, load, clk_ena, clr_overflow, clr_underflow
//   From counter: overflow, underflow;  to CPU: irq
// Latency: register writes, pulses and irq update one clk after the APB access edge;
//   prdata/pslverr are combinational. No backpressure: pready is tied high.
module timer_ctrl #(
  parameter logic [7:0] ADDR_TDR = 8'h00,
  parameter logic [7:0] ADDR_TCR = 8'h01,
  parameter logic [7:0] ADDR_TSR = 8'h02,
  parameter logic [7:0] ADDR_TIE = 8'h03
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [7:0] start_counter,
  output logic       up_down,
  output logic       enable,
  output logic       load,
  output logic       clk_ena,
  output logic       clr_overflow,
  output logic       clr_underflow,
  input  logic       overflow,
  input  logic       underflow,
  output logic       irq
);

  logic [7:0] tdr;
  logic       ud;
  logic       en;
  logic [1:0] cks;
  logic [1:0] tie;
  logic [3:0] div_cnt;
  logic [3:0] div_mask;

  logic hit_tdr, hit_tcr, hit_tsr, hit_tie, mapped, wr;

  assign hit_tdr = (paddr == ADDR_TDR);
  assign hit_tcr = (paddr == ADDR_TCR);
  assign hit_tsr = (paddr == ADDR_TSR);
  assign hit_tie = (paddr == ADDR_TIE);
  assign mapped  = hit_tdr | hit_tcr | hit_tsr | hit_tie;
  assign wr      = psel & penable & pwrite;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdr           <= 8'h00;
      ud            <= 1'b0;
      en            <= 1'b0;
      cks           <= 2'b00;
      tie           <= 2'b00;
      div_cnt       <= 4'h0;
      load          <= 1'b0;
      clr_overflow  <= 1'b0;
      clr_underflow <= 1'b0;
      irq           <= 1'b0;
    end else begin
      // Strobes are one cycle wide: they are recomputed every cycle from the
      // current access, so they fall as soon as the write phase is over.
      load          <= wr & hit_tcr & pwdata[7];
      clr_overflow  <= wr & hit_tsr & pwdata[0];
      clr_underflow <= wr & hit_tsr & pwdata[1];
      if (wr && hit_tdr) tdr <= pwdata;
      if (wr && hit_tcr) begin
        ud  <= pwdata[5];
        en  <= pwdata[4];
        cks <= pwdata[1:0];
      end
      if (wr && hit_tie) tie <= pwdata[1:0];
      // A load restarts the prescaler so the first tick after a reload is a
      // full period away. A CKS change alone does not restart it.
      div_cnt <= (en && !load) ? div_cnt + 4'd1 : 4'd0;
      irq     <= |({underflow, overflow} & tie);
    end
  end

  always_comb begin
    div_mask = 4'b0001;
    case (cks)
      2'd0: div_mask = 4'b0001;
      2'd1: div_mask = 4'b0011;
      2'd2: div_mask = 4'b0111;
      2'd3: div_mask = 4'b1111;
      default: div_mask = 4'b0001;
    endcase
  end

  // The counter is being reloaded during the load cycle, so no tick then.
  assign clk_ena = en & ~load & ((div_cnt & div_mask) == div_mask);

  always_comb begin
    prdata = 8'h00;
    if (psel && !pwrite) begin
      if (hit_tdr)      prdata = tdr;
      else if (hit_tcr) prdata = {2'b00, ud, en, 2'b00, cks};
      else if (hit_tsr) prdata = {6'b0, underflow, overflow};
      else if (hit_tie) prdata = {6'b0, tie};
      else              prdata = 8'h00;
    end
  end

  assign pslverr       = psel & penable & ~mapped;
  assign pready        = 1'b1;
  assign start_counter = tdr;
  assign up_down       = ud;
  assign enable        = en;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: randomized scoreboard bench for timer_ctrl with a behavioural
//   reference model and a small behavioural 8-bit counter closing the loop.
// Per-cycle expected outputs and per-access APB responses are queued by the
//   model/driver and popped by a monitor on the falling edge.
module tb_timer_ctrl;

  localparam logic [7:0] A_TDR = 8'h00;
  localparam logic [7:0] A_TCR = 8'h01;
  localparam logic [7:0] A_TSR = 8'h02;
  localparam logic [7:0] A_TIE = 8'h03;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = 8'h00, pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic [7:0] start_counter;
  logic       up_down, enable, load, clk_ena, clr_overflow, clr_underflow, irq;
  logic       overflow = 1'b0, underflow = 1'b0;

  timer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .start_counter(start_counter), .up_down(up_down), .enable(enable), .load(load),
    .clk_ena(clk_ena), .clr_overflow(clr_overflow), .clr_underflow(clr_underflow),
    .overflow(overflow), .underflow(underflow), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural counter the controller drives.
  logic [7:0] cnt = 8'h00;
  always @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 8'h00; overflow <= 1'b0; underflow <= 1'b0;
    end else begin
      if (load) cnt <= start_counter;
      else if (clk_ena) cnt <= up_down ? cnt + 8'd1 : cnt - 8'd1;
      if (!load && clk_ena && up_down && cnt == 8'hFF) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
      if (!load && clk_ena && !up_down && cnt == 8'h00) underflow <= 1'b1;
      else if (clr_underflow) underflow <= 1'b0;
    end
  end

  typedef struct packed {
    logic       load;
    logic       clk_ena;
    logic       clr_o;
    logic       clr_u;
    logic       irq;
    logic       ud;
    logic       en;
    logic [7:0] start;
    logic       pready;
  } cyc_t;

  typedef struct packed {
    logic       is_read;
    logic       err;
    logic [7:0] data;
  } apb_t;

  cyc_t exp_q[$];
  apb_t apb_q[$];

  // Reference model: register file, pending strobes, and the number of cycles
  // the prescaler has been running since it was last restarted.
  logic [7:0] m_tdr = 8'h00;
  logic       m_ud = 1'b0, m_en = 1'b0;
  logic [1:0] m_cks = 2'b00, m_tie = 2'b00;
  logic       m_load = 1'b0, m_clro = 1'b0, m_clru = 1'b0, m_irq = 1'b0;
  int         m_run = 0;

  function automatic logic m_tick();
    int period;
    period = 2 << m_cks;
    return m_en && !m_load && ((m_run % period) == period - 1);
  endfunction

  always @(posedge clk) begin
    logic w;
    cyc_t e;
    if (!rst_n) begin
      m_tdr = 8'h00; m_ud = 1'b0; m_en = 1'b0; m_cks = 2'b00; m_tie = 2'b00;
      m_load = 1'b0; m_clro = 1'b0; m_clru = 1'b0; m_irq = 1'b0; m_run = 0;
    end else begin
      w = psel && penable && pwrite;
      m_run  = (m_en && !m_load) ? m_run + 1 : 0;
      m_irq  = (overflow && m_tie[0]) || (underflow && m_tie[1]);
      m_load = w && paddr == A_TCR && pwdata[7];
      m_clro = w && paddr == A_TSR && pwdata[0];
      m_clru = w && paddr == A_TSR && pwdata[1];
      if (w && paddr == A_TDR) m_tdr = pwdata;
      if (w && paddr == A_TCR) begin
        m_ud = pwdata[5]; m_en = pwdata[4]; m_cks = pwdata[1:0];
      end
      if (w && paddr == A_TIE) m_tie = pwdata[1:0];
    end
    e.load = m_load; e.clk_ena = m_tick(); e.clr_o = m_clro; e.clr_u = m_clru;
    e.irq = m_irq; e.ud = m_ud; e.en = m_en; e.start = m_tdr; e.pready = 1'b1;
    exp_q.push_back(e);
  end

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      A_TDR:   return m_tdr;
      A_TCR:   return {2'b00, m_ud, m_en, 2'b00, m_cks};
      A_TSR:   return {6'b0, underflow, overflow};
      A_TIE:   return {6'b0, m_tie};
      default: return 8'h00;
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    cyc_t e, a;
    apb_t p;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.load = load; a.clk_ena = clk_ena; a.clr_o = clr_overflow; a.clr_u = clr_underflow;
      a.irq = irq; a.ud = up_down; a.en = enable; a.start = start_counter; a.pready = pready;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got load=%b ena=%b clro=%b clru=%b irq=%b ud=%b en=%b start=%h rdy=%b expected load=%b ena=%b clro=%b clru=%b irq=%b ud=%b en=%b start=%h rdy=%b",
                 $time, a.load, a.clk_ena, a.clr_o, a.clr_u, a.irq, a.ud, a.en, a.start, a.pready,
                 e.load, e.clk_ena, e.clr_o, e.clr_u, e.irq, e.ud, e.en, e.start, e.pready);
      end
    end
    if (psel && penable) begin
      checks++;
      if (apb_q.size() == 0) begin
        errors++;
        $display("FAIL apb_queue t=%0t access phase with no expected response", $time);
      end else begin
        p = apb_q.pop_front();
        if (pslverr !== p.err || (p.is_read && prdata !== p.data)) begin
          errors++;
          $display("FAIL apb t=%0t addr=%h got pslverr=%b prdata=%h expected pslverr=%b prdata=%h",
                   $time, paddr, pslverr, prdata, p.err, p.is_read ? p.data : prdata);
        end
      end
    end else if (rst_n) begin
      checks++;
      if (pslverr !== 1'b0 || (!(psel && !pwrite) && prdata !== 8'h00)) begin
        errors++;
        $display("FAIL apb_idle t=%0t got pslverr=%b prdata=%h expected 0 and 00", $time, pslverr, prdata);
      end
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic unmapped(input logic [7:0] a);
    return a > 8'h03;
  endfunction

  task automatic apb_wr(input logic [7:0] a, input logic [7:0] d);
    apb_t p;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    cyc();
    penable = 1'b1;
    p.is_read = 1'b0; p.err = unmapped(a); p.data = 8'h00;
    apb_q.push_back(p);
    cyc();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a);
    apb_t p;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    cyc();
    penable = 1'b1;
    p.is_read = 1'b1; p.err = unmapped(a); p.data = m_read(a);
    apb_q.push_back(p);
    cyc();
    psel = 1'b0; penable = 1'b0;
  endtask

  // Counts clk_ena ticks over n cycles and records the largest/smallest gap.
  task automatic count_ticks(input int n, output int ticks, output int gmin, output int gmax);
    int last;
    ticks = 0; gmin = 1000; gmax = 0; last = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (clk_ena) begin
        if (last >= 0) begin
          if (i - last < gmin) gmin = i - last;
          if (i - last > gmax) gmax = i - last;
        end
        last = i;
        ticks++;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int t, gmin, gmax, budget;
    logic seen;
    logic [7:0] d;
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Reload FE, count up every 2nd cycle, wrap to overflow.
    apb_wr(A_TDR, 8'hFE);
    apb_wr(A_TCR, 8'hB0);
    seen = 1'b0;
    budget = 30;
    while (!seen && budget > 0) begin
      cyc();
      seen = overflow;
      budget--;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL overflow_wrap got no overflow within 30 cycles expected overflow set");
    end

    // Interrupt on overflow, then clear it.
    apb_wr(A_TIE, 8'h01);
    cyc(3);
    apb_wr(A_TCR, 8'h00);
    apb_wr(A_TSR, 8'h01);
    cyc(3);

    // Slowest prescaler: exactly every 16 cycles; EN=0 stops ticks.
    apb_wr(A_TCR, 8'h13);
    count_ticks(80, t, gmin, gmax);
    checks++;
    if (t != 5 || gmin != 16 || gmax != 16) begin
      errors++;
      $display("FAIL cks3_period got ticks=%0d gaps=%0d..%0d expected ticks=5 gaps=16..16", t, gmin, gmax);
    end
    apb_wr(A_TCR, 8'h03);
    count_ticks(40, t, gmin, gmax);
    checks++;
    if (t != 0) begin
      errors++;
      $display("FAIL en_off got ticks=%0d expected 0", t);
    end

    // Unmapped access, and LOAD reads back as zero.
    apb_wr(8'h07, 8'hFF);
    apb_rd(8'h07);
    apb_wr(A_TCR, 8'hB3);
    apb_rd(A_TCR);
    apb_rd(A_TDR);
    apb_rd(A_TIE);
    apb_wr(A_TSR, 8'h03);
    apb_wr(A_TSR, 8'h00);
    apb_rd(A_TSR);

    // Reset in the load cycle with the prescaler running.
    apb_wr(A_TCR, 8'h00);
    apb_wr(A_TCR, 8'h90);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    count_ticks(40, t, gmin, gmax);
    checks++;
    if (t != 0) begin
      errors++;
      $display("FAIL post_reset_ticks got ticks=%0d expected 0", t);
    end

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 11))
        0, 1: begin
          d = 8'($urandom);
          d[4] = ($urandom_range(0, 3) != 0);
          d[7] = ($urandom_range(0, 2) == 0);
          apb_wr(A_TCR, d);
        end
        2: apb_wr(A_TDR, 8'($urandom));
        3: apb_wr(A_TSR, 8'($urandom_range(0, 3)));
        4: apb_wr(A_TIE, 8'($urandom));
        5: apb_wr(8'($urandom_range(4, 255)), 8'($urandom));
        6, 7: apb_rd(8'($urandom_range(0, 7)));
        8: begin
          if ($urandom_range(0, 15) == 0) begin
            rst_n = 1'b0;
            cyc();
            rst_n = 1'b1;
          end else cyc();
        end
        default: cyc($urandom_range(1, 20));
      endcase
    end

    cyc(2);
    @(negedge clk);
    #1;
    checks++;
    if (apb_q.size() != 0) begin
      errors++;
      $display("FAIL apb_drain got %0d pending expected 0", apb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
